load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 60 ++++++
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_extend.sv | 31 +++
 rtl/load_store_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access sizes
// and the RISC-V funct3 encodings for loads and stores.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // The low two funct3 bits encode the access size for both loads and stores.
    function automatic size_e funct3_size(input logic [2:0] funct3);
        return size_e'(funct3[1:0]);
    endfunction

    function automatic logic [2:0] align_mask(input size_e size);
        logic [2:0] mask;
        case (size)
            SZ_BYTE:   mask = 3'b000;
            SZ_HALF:   mask = 3'b001;
            SZ_WORD:   mask = 3'b011;
            SZ_DOUBLE: mask = 3'b111;
            default:   mask = 3'b111;
        endcase
        return mask;
    endfunction

    function automatic logic funct3_illegal(input logic write, input logic [2:0] funct3);
        logic bad;
        if (write) begin
            bad = funct3[2];
        end else begin
            bad = (funct3 == 3'b111);
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// master = upstream core plus memory, slave = the unit itself.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic                  req_write_in;
    logic [2:0]            req_funct3_in;
    logic [ADDR_WIDTH-1:0] req_address_in;
    logic [DATA_WIDTH-1:0] req_data_in;
    logic                  resp_valid_out;
    logic [DATA_WIDTH-1:0] resp_data_out;
    logic                  resp_error_out;
    logic [ADDR_WIDTH-1:0] mem_address_out;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_writeEnable_out;
    logic                  mem_readEnable_out;
    logic [DATA_WIDTH-1:0] mem_data_in;

    modport slave (
        input  req_valid_in, req_write_in, req_funct3_in, req_address_in, req_data_in,
        input  mem_data_in,
        output req_ready_out, resp_valid_out, resp_data_out, resp_error_out,
        output mem_address_out, mem_data_out, mem_writeEnable_out, mem_readEnable_out
    );

    modport master (
        output req_valid_in, req_write_in, req_funct3_in, req_address_in, req_data_in,
        output mem_data_in,
        input  req_ready_out, resp_valid_out, resp_data_out, resp_error_out,
        input  mem_address_out, mem_data_out, mem_writeEnable_out, mem_readEnable_out
    );

endinterface

// File: rtl/load_extend.sv
// Combinational load lane selection: picks the addressed bytes out of a
// little-endian doubleword and sign- or zero-extends them per funct3.
module load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] dword,
    input  logic [2:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] shifted_s;

    // Shift the addressed lane down to bit 0, then extend it.
    always_comb begin
        shifted_s = dword >> {offset, 3'b000};
        case (funct3)
            F3_LB:   result = {{(DATA_WIDTH-8){shifted_s[7]}},   shifted_s[7:0]};
            F3_LH:   result = {{(DATA_WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_LW:   result = {{(DATA_WIDTH-32){shifted_s[31]}}, shifted_s[31:0]};
            F3_LD:   result = shifted_s;
            F3_LBU:  result = {{(DATA_WIDTH-8){1'b0}},  shifted_s[7:0]};
            F3_LHU:  result = {{(DATA_WIDTH-16){1'b0}}, shifted_s[15:0]};
            F3_LWU:  result = {{(DATA_WIDTH-32){1'b0}}, shifted_s[31:0]};
            default: result = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a doubleword data memory.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned accesses instead of aligning them down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_2POW = 12
) (
    input  logic             clk_in,
    input  logic             reset_in,
    load_store_unit_if.slave bus
);

    state_e                state_r;
    state_e                state_nx_s;

    logic                  write_r;
    logic [2:0]            funct3_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;

    logic                  fld_write_s;
    logic [2:0]            fld_funct3_s;
    logic [ADDR_WIDTH-1:0] fld_addr_s;
    logic [DATA_WIDTH-1:0] fld_data_s;

    size_e                 size_s;
    logic [2:0]            amask_s;
    logic                  illegal_s;
    logic                  range_err_s;
    logic                  error_s;
    logic                  is_sd_s;
    logic                  accept_s;
    logic [ADDR_WIDTH-1:0] eff_addr_s;
    logic [2:0]            offset_s;
`ifdef LSU_MISALIGN_CHECK_EN
    logic                  misalign_s;
`endif

    logic [DATA_WIDTH-1:0] lane_s;
    logic [DATA_WIDTH-1:0] byte_mask_s;
    logic [DATA_WIDTH-1:0] store_shift_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic [DATA_WIDTH-1:0] load_result_s;

    logic                  ready_r,      ready_nx_s;
    logic                  resp_valid_r, resp_valid_nx_s;
    logic [DATA_WIDTH-1:0] resp_data_r,  resp_data_nx_s;
    logic                  resp_error_r, resp_error_nx_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r,   mem_addr_nx_s;
    logic [DATA_WIDTH-1:0] mem_data_r,   mem_data_nx_s;
    logic                  mem_we_r,     mem_we_nx_s;
    logic                  mem_re_r,     mem_re_nx_s;

    assign accept_s = (state_r == ST_IDLE) && bus.req_valid_in;

    // In IDLE the live request is decoded so the accept edge can already act on it.
    always_comb begin
        if (state_r == ST_IDLE) begin
            fld_write_s  = bus.req_write_in;
            fld_funct3_s = bus.req_funct3_in;
            fld_addr_s   = bus.req_address_in;
            fld_data_s   = bus.req_data_in;
        end else begin
            fld_write_s  = write_r;
            fld_funct3_s = funct3_r;
            fld_addr_s   = addr_r;
            fld_data_s   = data_r;
        end
    end

    // Request legality, effective (aligned) address and byte offset.
    always_comb begin
        size_s      = funct3_size(fld_funct3_s);
        amask_s     = align_mask(size_s);
        illegal_s   = funct3_illegal(fld_write_s, fld_funct3_s);
        range_err_s = |fld_addr_s[ADDR_WIDTH-1:DEPTH_2POW+3];
`ifdef LSU_MISALIGN_CHECK_EN
        misalign_s  = |(fld_addr_s[2:0] & amask_s);
        error_s     = illegal_s | range_err_s | misalign_s;
`else
        error_s     = illegal_s | range_err_s;
`endif
        eff_addr_s  = {fld_addr_s[ADDR_WIDTH-1:3], fld_addr_s[2:0] & ~amask_s};
        offset_s    = eff_addr_s[2:0];
        is_sd_s     = fld_write_s && (size_s == SZ_DOUBLE);
    end

    // Read-modify-write merge of sub-doubleword store data into the fetched doubleword.
    always_comb begin
        case (size_s)
            SZ_BYTE:   lane_s = DATA_WIDTH'(64'h0000_0000_0000_00FF);
            SZ_HALF:   lane_s = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
            SZ_WORD:   lane_s = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
            SZ_DOUBLE: lane_s = {DATA_WIDTH{1'b1}};
            default:   lane_s = {DATA_WIDTH{1'b1}};
        endcase
        byte_mask_s   = lane_s << {offset_s, 3'b000};
        store_shift_s = (fld_data_s & lane_s) << {offset_s, 3'b000};
        merged_s      = (bus.mem_data_in & ~byte_mask_s) | store_shift_s;
    end

    load_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extend (
        .dword  (bus.mem_data_in),
        .offset (offset_s),
        .funct3 (fld_funct3_s),
        .result (load_result_s)
    );

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = error_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_nx_s = is_sd_s ? ST_RESP : ST_WAIT;
            ST_WAIT:   state_nx_s = fld_write_s ? ST_WRITE : ST_RESP;
            ST_WRITE:  state_nx_s = ST_RESP;
            ST_RESP:   state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        ready_nx_s      = (state_nx_s == ST_IDLE);
        resp_valid_nx_s = (state_nx_s == ST_RESP);
        resp_error_nx_s = (state_nx_s == ST_RESP) && error_s;
        mem_re_nx_s     = (state_nx_s == ST_ACCESS) && !is_sd_s;
        mem_we_nx_s     = ((state_nx_s == ST_ACCESS) && is_sd_s) || (state_nx_s == ST_WRITE);
        if ((state_nx_s == ST_RESP) && (state_r == ST_WAIT) && !fld_write_s) begin
            resp_data_nx_s = load_result_s;
        end else begin
            resp_data_nx_s = {DATA_WIDTH{1'b0}};
        end
        if (mem_re_nx_s || mem_we_nx_s) begin
            mem_addr_nx_s = {eff_addr_s[ADDR_WIDTH-1:3], 3'b000};
        end else begin
            mem_addr_nx_s = {ADDR_WIDTH{1'b0}};
        end
        if (state_nx_s == ST_WRITE) begin
            mem_data_nx_s = merged_s;
        end else if (mem_we_nx_s) begin
            mem_data_nx_s = fld_data_s;
        end else begin
            mem_data_nx_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Captured request fields, loaded on the accept edge.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            write_r  <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= {ADDR_WIDTH{1'b0}};
            data_r   <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            write_r  <= bus.req_write_in;
            funct3_r <= bus.req_funct3_in;
            addr_r   <= bus.req_address_in;
            data_r   <= bus.req_data_in;
        end
    end

    // Output registers.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_data_r  <= {DATA_WIDTH{1'b0}};
            resp_error_r <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_data_r   <= {DATA_WIDTH{1'b0}};
            mem_we_r     <= 1'b0;
            mem_re_r     <= 1'b0;
        end else begin
            ready_r      <= ready_nx_s;
            resp_valid_r <= resp_valid_nx_s;
            resp_data_r  <= resp_data_nx_s;
            resp_error_r <= resp_error_nx_s;
            mem_addr_r   <= mem_addr_nx_s;
            mem_data_r   <= mem_data_nx_s;
            mem_we_r     <= mem_we_nx_s;
            mem_re_r     <= mem_re_nx_s;
        end
    end

    assign bus.req_ready_out       = ready_r;
    assign bus.resp_valid_out      = resp_valid_r;
    assign bus.resp_data_out       = resp_data_r;
    assign bus.resp_error_out      = resp_error_r;
    assign bus.mem_address_out     = mem_addr_r;
    assign bus.mem_data_out        = mem_data_r;
    assign bus.mem_writeEnable_out = mem_we_r;
    assign bus.mem_readEnable_out  = mem_re_r;

endmodule
